y86_fd_regs: RTL

Y86_FD_REGS -- requirements
Module: y86_fd_regs

---
 rtl/y86_fd_regs.sv | 123 ++++++++++++
 1 files changed

// File: rtl/y86_fd_regs.sv
// Fetch (F) and decode (D) pipeline registers of a Y86 pipeline, with the
// hazard-control logic that decides stall and bubble for both stages.
module y86_fd_regs (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Fin_predPC,
   input  logic [3:0]  Din_stat,
   input  logic [3:0]  Din_icode,
   input  logic [3:0]  Din_ifun,
   input  logic [3:0]  Din_rA,
   input  logic [3:0]  Din_rB,
   input  logic [31:0] Din_valC,
   input  logic [31:0] Din_valP,
   input  logic [3:0]  d_srcA,
   input  logic [3:0]  d_srcB,
   input  logic [3:0]  Eout_icode,
   input  logic [3:0]  Eout_dstM,
   input  logic        e_Cnd,
   input  logic [3:0]  Mout_icode,
   output logic [31:0] Fout_predPC,
   output logic [3:0]  Dout_stat,
   output logic [3:0]  Dout_icode,
   output logic [3:0]  Dout_ifun,
   output logic [3:0]  Dout_rA,
   output logic [3:0]  Dout_rB,
   output logic [31:0] Dout_valC,
   output logic [31:0] Dout_valP,
   output logic        F_stall,
   output logic        D_stall,
   output logic        D_bubble,
   output logic        E_bubble
);

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_MRMOVL = 4'h5;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPL   = 4'hB;
   localparam logic [3:0] R_NONE   = 4'hF;
   localparam logic [3:0] S_OK     = 4'h1;

   logic w_load_use;
   logic w_ret_pending;
   logic w_mispredict;
   logic w_e_is_load;

   logic [31:0] r_pred_pc;
   logic [3:0]  r_stat;
   logic [3:0]  r_icode;
   logic [3:0]  r_ifun;
   logic [3:0]  r_ra;
   logic [3:0]  r_rb;
   logic [31:0] r_valc;
   logic [31:0] r_valp;

   assign w_e_is_load   = (Eout_icode == I_MRMOVL) || (Eout_icode == I_POPL);
   assign w_load_use    = w_e_is_load && (Eout_dstM != R_NONE) &&
                          ((Eout_dstM == d_srcA) || (Eout_dstM == d_srcB));
   assign w_ret_pending = (r_icode == I_RET) || (Eout_icode == I_RET) ||
                          (Mout_icode == I_RET);
   assign w_mispredict  = (Eout_icode == I_JXX) && !e_Cnd;

   // A load/use stall takes precedence over the RET bubble so the RET in D
   // is held rather than squashed.
   assign F_stall  = w_load_use | w_ret_pending;
   assign D_stall  = w_load_use;
   assign D_bubble = w_mispredict | (w_ret_pending & ~w_load_use);
   assign E_bubble = w_mispredict | w_load_use;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pred_pc <= 32'h0;
      end else if (!F_stall) begin
         r_pred_pc <= Fin_predPC;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat  <= S_OK;
         r_icode <= I_NOP;
         r_ifun  <= 4'h0;
         r_ra    <= R_NONE;
         r_rb    <= R_NONE;
         r_valc  <= 32'h0;
         r_valp  <= 32'h0;
      end else if (D_stall) begin
         r_stat  <= r_stat;
         r_icode <= r_icode;
         r_ifun  <= r_ifun;
         r_ra    <= r_ra;
         r_rb    <= r_rb;
         r_valc  <= r_valc;
         r_valp  <= r_valp;
      end else if (D_bubble) begin
         r_stat  <= S_OK;
         r_icode <= I_NOP;
         r_ifun  <= 4'h0;
         r_ra    <= R_NONE;
         r_rb    <= R_NONE;
         r_valc  <= 32'h0;
         r_valp  <= 32'h0;
      end else begin
         r_stat  <= Din_stat;
         r_icode <= Din_icode;
         r_ifun  <= Din_ifun;
         r_ra    <= Din_rA;
         r_rb    <= Din_rB;
         r_valc  <= Din_valC;
         r_valp  <= Din_valP;
      end
   end

   assign Fout_predPC = r_pred_pc;
   assign Dout_stat   = r_stat;
   assign Dout_icode  = r_icode;
   assign Dout_ifun   = r_ifun;
   assign Dout_rA     = r_ra;
   assign Dout_rB     = r_rb;
   assign Dout_valC   = r_valc;
   assign Dout_valP   = r_valp;

endmodule
